// File: rtl/w5300_pif_engine.sv
// W5300 parallel-interface bus engine: turns single-word requests into timed
// address/strobe/hold/recovery cycles on an 8- or 16-bit asynchronous bus.
// Ports: clk, rst_n; request side req_valid/req_ready/req_wr/req_addr/
//   req_wdata; response side done/rsp_rdata; pad side bus_addr/bus_dout/
//   bus_oe/bus_din and active-low strobes cs_n/rd_n/we_n.
module w5300_pif_engine #(
   parameter int ADDR_W = 10,
   parameter int BUS_W  = 16,
   parameter int T_AS   = 1,
   parameter int T_PW   = 2,
   parameter int T_HOLD = 1,
   parameter int T_REC  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              done,
   output logic [15:0]       rsp_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [BUS_W-1:0]  bus_dout,
   output logic              bus_oe,
   input  logic [BUS_W-1:0]  bus_din,
   output logic              cs_n,
   output logic              rd_n,
   output logic              we_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_STROBE,
      S_HOLD,
      S_RECOV
   } state_t;

   localparam int         PHASES = (BUS_W == 8) ? 2 : 1;
   localparam logic       LAST_PH = 1'(PHASES - 1);
   localparam logic [3:0] C_AS   = 4'(T_AS - 1);
   localparam logic [3:0] C_PW   = 4'(T_PW - 1);
   localparam logic [3:0] C_HOLD = 4'(T_HOLD - 1);
   localparam logic [3:0] C_REC  = 4'(T_REC - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              phase_q;
   logic              wr_q;
   logic [7:0]        lo_q;
   logic [15:0]       cap_q;
   logic [15:0]       rsp_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BUS_W-1:0]  dout_q;

   logic              accept;
   logic              phase_adv;
   logic              last_strobe;
   logic              done_c;
   logic [15:0]       din_ext;
   logic [15:0]       d_first;
   logic [15:0]       d_second;
   logic [ADDR_W-1:0] a_first;

   // Counter holds "cycles left after this one"; each state exits at zero.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      accept      = 1'b0;
      phase_adv   = 1'b0;
      last_strobe = 1'b0;
      done_c      = 1'b0;
      if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = S_ADDR;
               cnt_d   = C_AS;
            end
         end
         S_ADDR: begin
            if (cnt_q == 4'd0) begin
               state_d = S_STROBE;
               cnt_d   = C_PW;
            end
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               last_strobe = 1'b1;
               state_d     = S_HOLD;
               cnt_d       = C_HOLD;
            end
         end
         S_HOLD: begin
            if (cnt_q == 4'd0) begin
               if (phase_q == LAST_PH) begin
                  done_c  = 1'b1;
                  state_d = S_RECOV;
                  cnt_d   = C_REC;
               end else begin
                  phase_adv = 1'b1;
                  state_d   = S_ADDR;
                  cnt_d     = C_AS;
               end
            end
         end
         S_RECOV: begin
            if (cnt_q == 4'd0) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Byte-wide bus: high byte at the even address first, then low byte.
   always_comb begin
      din_ext = '0;
      din_ext[BUS_W-1:0] = bus_din;
      a_first = req_addr;
      if (PHASES == 2) begin
         a_first[0] = 1'b0;
         d_first    = {8'h00, req_wdata[15:8]};
      end else begin
         d_first    = req_wdata;
      end
      d_second = {8'h00, lo_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         phase_q <= 1'b0;
         wr_q    <= 1'b0;
         lo_q    <= 8'h00;
         cap_q   <= 16'h0000;
         rsp_q   <= 16'h0000;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            phase_q <= 1'b0;
            wr_q    <= req_wr;
            lo_q    <= req_wdata[7:0];
            addr_q  <= a_first;
            dout_q  <= d_first[BUS_W-1:0];
         end
         if (phase_adv) begin
            phase_q   <= 1'b1;
            addr_q[0] <= 1'b1;
            dout_q    <= d_second[BUS_W-1:0];
         end
         if (last_strobe) begin
            if (PHASES == 1) cap_q <= din_ext;
            else if (!phase_q) cap_q[15:8] <= din_ext[7:0];
            else cap_q[7:0] <= din_ext[7:0];
         end
         if (done_c && !wr_q) rsp_q <= cap_q;
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   always_comb begin
      req_ready = (state_q == S_IDLE);
      done      = done_c;
      cs_n      = !(state_q == S_STROBE);
      rd_n      = !((state_q == S_STROBE) && !wr_q);
      we_n      = !((state_q == S_STROBE) && wr_q);
      bus_oe    = wr_q && ((state_q == S_ADDR) ||
                           (state_q == S_STROBE) ||
                           (state_q == S_HOLD));
      bus_addr  = addr_q;
      bus_dout  = dout_q;
      rsp_rdata = (done_c && !wr_q) ? cap_q : rsp_q;
   end

endmodule

// File: tb/tb_w5300_pif_engine.sv
// Self-checking bench for w5300_pif_engine: three instances (defaults,
// 8-bit bus, stretched strobe/recovery) with a done-driven scoreboard.
module tb_w5300_pif_engine;

   typedef struct {
      logic        rd;
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   logic        v0, w0, rdy0, dn0, oe0, cs0, rdn0, wen0;
   logic [9:0]  a0, ba0;
   logic [15:0] wd0, rsp0, bo0, di0;

   logic        v1, w1, rdy1, dn1, oe1, cs1, rdn1, wen1;
   logic [9:0]  a1, ba1;
   logic [15:0] wd1, rsp1;
   logic [7:0]  bo1, di1;

   logic        v2, w2, rdy2, dn2, oe2, cs2, rdn2, wen2;
   logic [9:0]  a2, ba2;
   logic [15:0] wd2, rsp2, bo2, di2;

   w5300_pif_engine u0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v0), .req_ready(rdy0), .req_wr(w0),
      .req_addr(a0), .req_wdata(wd0),
      .done(dn0), .rsp_rdata(rsp0),
      .bus_addr(ba0), .bus_dout(bo0), .bus_oe(oe0), .bus_din(di0),
      .cs_n(cs0), .rd_n(rdn0), .we_n(wen0)
   );

   w5300_pif_engine #(.BUS_W(8)) u1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v1), .req_ready(rdy1), .req_wr(w1),
      .req_addr(a1), .req_wdata(wd1),
      .done(dn1), .rsp_rdata(rsp1),
      .bus_addr(ba1), .bus_dout(bo1), .bus_oe(oe1), .bus_din(di1),
      .cs_n(cs1), .rd_n(rdn1), .we_n(wen1)
   );

   w5300_pif_engine #(.T_PW(4), .T_REC(3)) u2 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(v2), .req_ready(rdy2), .req_wr(w2),
      .req_addr(a2), .req_wdata(wd2),
      .done(dn2), .rsp_rdata(rsp2),
      .bus_addr(ba2), .bus_dout(bo2), .bus_oe(oe2), .bus_din(di2),
      .cs_n(cs2), .rd_n(rdn2), .we_n(wen2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && dn0) begin
         if (q0.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL d0_unexpected: got done at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("d0_cycle", cyc, e.cyc);
            if (e.rd) chk("d0_rdata", rsp0, e.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && dn1) begin
         if (q1.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL d1_unexpected: got done at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("d1_cycle", cyc, e.cyc);
            if (e.rd) chk("d1_rdata", rsp1, e.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && dn2) begin
         if (q2.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL d2_unexpected: got done at cycle %0d expected none", cyc);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("d2_cycle", cyc, e.cyc);
            if (e.rd) chk("d2_rdata", rsp2, e.data);
         end
      end
   end

   initial begin
      int a;
      int nlow;
      rst_n = 1'b0;
      {v0, w0, a0, wd0, di0} = '0;
      {v1, w1, a1, wd1, di1} = '0;
      {v2, w2, a2, wd2, di2} = '0;

      @(negedge clk);
      chk("rst_ready", rdy0, 1);
      chk("rst_done", dn0, 0);
      chk("rst_cs", cs0, 1);
      chk("rst_rd", rdn0, 1);
      chk("rst_we", wen0, 1);
      chk("rst_oe", oe0, 0);
      chk("rst_addr", ba0, 0);
      chk("rst_dout", bo0, 0);
      chk("rst_rdata", rsp0, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // default write
      a0 = 10'h123; wd0 = 16'hBEEF; w0 = 1'b1; v0 = 1'b1;
      a = cyc;
      q0.push_back('{1'b0, 16'h0000, a + 4});
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) v0 = 1'b0;
         chk("wr_oe", oe0, (i <= 4));
         chk("wr_we", wen0, !(i == 2 || i == 3));
         chk("wr_cs", cs0, !(i == 2 || i == 3));
         chk("wr_rd", rdn0, 1);
         chk("wr_ready", rdy0, (i == 6));
         if (i == 2) begin
            chk("wr_addr", ba0, 10'h123);
            chk("wr_dout", bo0, 16'hBEEF);
         end
      end
      repeat (2) @(negedge clk);

      // default read
      di0 = 16'hA5C3; a0 = 10'h045; w0 = 1'b0; v0 = 1'b1;
      a = cyc;
      q0.push_back('{1'b1, 16'hA5C3, a + 4});
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (i == 1) v0 = 1'b0;
         chk("rd_rd", rdn0, !(i == 2 || i == 3));
         chk("rd_we", wen0, 1);
         chk("rd_oe", oe0, 0);
         chk("rd_ready", rdy0, (i == 6));
      end
      chk("rd_hold", rsp0, 16'hA5C3);
      di0 = 16'h0000;

      // back-to-back writes with valid held high
      a0 = 10'h200; wd0 = 16'h5555; w0 = 1'b1; v0 = 1'b1;
      a = cyc;
      q0.push_back('{1'b0, 16'h0000, a + 4});
      q0.push_back('{1'b0, 16'h0000, a + 10});
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) wd0 = 16'h6666;
         chk("b2b_cs", cs0, !(i == 2 || i == 3 || i == 8 || i == 9));
         chk("b2b_ready", rdy0, (i == 6 || i == 12));
         if (i == 2) chk("b2b_dout0", bo0, 16'h5555);
         if (i == 6) chk("b2b_addr_held", ba0, 10'h200);
         if (i == 8) chk("b2b_dout1", bo0, 16'h6666);
         if (i == 7) v0 = 1'b0;
      end
      chk("wr_keeps_rdata", rsp0, 16'hA5C3);

      // reset in the middle of a strobe
      a0 = 10'h0F0; wd0 = 16'h1111; w0 = 1'b1; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      @(negedge clk);
      chk("mid_we_low", wen0, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_we", wen0, 1);
      chk("mid_cs", cs0, 1);
      chk("mid_oe", oe0, 0);
      chk("mid_ready", rdy0, 1);
      chk("mid_addr", ba0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_ready", rdy0, 1);
      end

      // 8-bit bus write
      a1 = 10'h00B; wd1 = 16'h1234; w1 = 1'b1; v1 = 1'b1;
      a = cyc;
      q1.push_back('{1'b0, 16'h0000, a + 8});
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) v1 = 1'b0;
         chk("b8w_we", wen1, !(i == 2 || i == 3 || i == 6 || i == 7));
         chk("b8w_oe", oe1, (i <= 8));
         chk("b8w_ready", rdy1, (i == 10));
         if (i == 2) begin
            chk("b8w_addr0", ba1, 10'h00A);
            chk("b8w_dout0", bo1, 8'h12);
         end
         if (i == 6) begin
            chk("b8w_addr1", ba1, 10'h00B);
            chk("b8w_dout1", bo1, 8'h34);
         end
      end

      // 8-bit bus read, byte lanes assembled high then low
      a1 = 10'h00B; w1 = 1'b0; di1 = 8'h5A; v1 = 1'b1;
      a = cyc;
      q1.push_back('{1'b1, 16'h5AC3, a + 8});
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) v1 = 1'b0;
         if (i == 5) di1 = 8'hC3;
         chk("b8r_rd", rdn1, !(i == 2 || i == 3 || i == 6 || i == 7));
         chk("b8r_oe", oe1, 0);
         chk("b8r_ready", rdy1, (i == 10));
      end

      // stretched strobe and recovery
      a2 = 10'h3FF; wd2 = 16'hC0DE; w2 = 1'b1; v2 = 1'b1;
      a = cyc;
      nlow = 0;
      q2.push_back('{1'b0, 16'h0000, a + 6});
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         if (i == 1) v2 = 1'b0;
         if (!wen2) nlow++;
         chk("lng_we", wen2, !(i >= 2 && i <= 5));
         chk("lng_ready", rdy2, (i >= 10));
      end
      chk("lng_pw_count", nlow, 4);

      repeat (3) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
